// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART receive path:
// FSM states, baud constants and the rounded divisor helper.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;
    localparam int unsigned BAUD_38400 = 38400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic ferr;
        logic perr;
    } rx_flags_t;

    // Rounded clk_hz / (OVERSAMPLE * baud), clamped to 1 so the tick counter always wraps.
    function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned baud);
        int unsigned den;
        int unsigned q;
        den = OVERSAMPLE * baud;
        q   = (clk_hz + den / 2) / den;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-side valid/ready stream: one character plus its error flags per beat.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_perr,
        output rx_ferr,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_perr,
        input  rx_ferr,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator with a runtime-selectable baud divisor.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       tick
);

    localparam int unsigned DIV_4800  = div_of(CLK_HZ, BAUD_4800);
    localparam int unsigned DIV_9600  = div_of(CLK_HZ, BAUD_9600);
    localparam int unsigned DIV_19200 = div_of(CLK_HZ, BAUD_19200);
    localparam int unsigned DIV_38400 = div_of(CLK_HZ, BAUD_38400);

    // The slowest rate has the largest divisor, so it sets the counter width.
    localparam int unsigned CW = (DIV_4800 > 1) ? $clog2(DIV_4800) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] wrap_at;
    logic [1:0]    br_q;

    always_comb begin
        case (br_cfg)
            2'b00:   wrap_at = CW'(DIV_4800 - 1);
            2'b01:   wrap_at = CW'(DIV_9600 - 1);
            2'b10:   wrap_at = CW'(DIV_19200 - 1);
            default: wrap_at = CW'(DIV_38400 - 1);
        endcase
    end

    // NOTE: clocked state is written with non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            br_q  <= br_cfg;
            tick  <= 1'b0;
        end else begin
            br_q <= br_cfg;
            tick <= 1'b0;
            if (br_cfg != br_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= wrap_at) begin
                // >= rather than == so a divisor switch mid-count can never run away.
                cnt_q <= '0;
                tick  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, 16x oversampling deframer with optional
// parity, and a first-word-fall-through receive FIFO with sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    input  logic [1:0]                  br_cfg,
    uart_rx_fifo_if.master              rx_if,
    output logic                        overrun,
    input  logic                        clr_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic        ODD_BIT  = (PARITY_ODD != 0);
    localparam logic        HAS_PAR  = (PARITY_EN != 0);

    // ---------------- synchroniser ----------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // ---------------- oversample tick ----------------
    logic tick;

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .br_cfg (br_cfg),
        .tick   (tick)
    );

    // ---------------- deframer FSM ----------------
    rx_state_e            state_q, state_d;
    logic [3:0]           sc_q, sc_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 brk_q, brk_d;
    logic                 push_q, push_d;
    logic [DATA_BITS-1:0] push_data_q, push_data_d;
    rx_flags_t            push_flags_q, push_flags_d;
    logic                 bit_end;

    assign bit_end = tick && (sc_q == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sc_q         <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            brk_q        <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            push_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            brk_q        <= brk_d;
            push_q       <= push_d;
            push_data_q  <= push_data_d;
            push_flags_q <= push_flags_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no
        // path leaves a variable unassigned and no latch is inferred.
        state_d      = state_q;
        sc_d         = sc_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        brk_d        = brk_q;
        push_d       = 1'b0;
        push_data_d  = push_data_q;
        push_flags_d = push_flags_q;

        if (tick && (state_q != ST_IDLE)) begin
            sc_d = sc_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                // After a framing error the line must return high before a new start is accepted.
                if (brk_q) begin
                    if (rxs) begin
                        brk_d = 1'b0;
                    end
                end else if (!rxs) begin
                    sc_d    = '0;
                    perr_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick && (sc_q == 4'd7)) begin
                    if (!rxs) begin
                        sc_d    = '0;
                        bit_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    perr_d  = ((^shreg_q) ^ rxs) != ODD_BIT;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    push_d            = 1'b1;
                    push_data_d       = shreg_q;
                    push_flags_d.ferr = !rxs;
                    push_flags_d.perr = perr_q;
                    brk_d             = !rxs;
                    state_d           = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- receive FIFO (FWFT) ----------------
    logic [DATA_BITS-1:0] mem_data  [FIFO_DEPTH];
    rx_flags_t            mem_flags [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 wr_en;
    logic                 drop;

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop   = !empty && rx_if.rx_ready;
    assign wr_en = push_q && (!full || pop);
    assign drop  = push_q && full && !pop;

    // NOTE: the storage array has no reset; the pointers and count are reset, and
    // the outputs are gated by empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr]  <= push_data_q;
            mem_flags[wr_ptr] <= push_flags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new drop wins over a simultaneous clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rx_if.rx_valid = !empty;
    assign rx_if.rx_data  = empty ? '0 : mem_data[rd_ptr];
    assign rx_if.rx_perr  = !empty && mem_flags[rd_ptr].perr;
    assign rx_if.rx_ferr  = !empty && mem_flags[rd_ptr].ferr;
    assign fifo_count     = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: three configurations (8N1, even parity,
// 4-deep FIFO) driven serially, with a per-instance expected-character scoreboard.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    // 1.2288 MHz gives divisors 16/8/4/2, keeping frames short in clock cycles.
    localparam int unsigned TB_CLK_HZ = 1_228_800;
    localparam int BIT_9600  = 128;
    localparam int BIT_38400 = 32;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         sel;
        logic [1:0] br;
        logic [7:0] data;
        logic       has_par;
        logic       par;
        logic       stop;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rxd_a, rxd_p, rxd_f;
    logic       clr_a, clr_p, clr_f;
    logic       ovr_a, ovr_p, ovr_f;
    logic [3:0] cnt_a, cnt_p;
    logic [2:0] cnt_f;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    exp_t q_a[$];
    exp_t q_p[$];
    exp_t q_f[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_p ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_f ();

    uart_rx_fifo #(.CLK_HZ(TB_CLK_HZ), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(8)) u_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .br_cfg(br_cfg), .rx_if(if_a),
        .overrun(ovr_a), .clr_err(clr_a), .fifo_count(cnt_a));

    uart_rx_fifo #(.CLK_HZ(TB_CLK_HZ), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(8)) u_p (
        .clk(clk), .rst(rst), .rxd(rxd_p), .br_cfg(br_cfg), .rx_if(if_p),
        .overrun(ovr_p), .clr_err(clr_p), .fifo_count(cnt_p));

    uart_rx_fifo #(.CLK_HZ(TB_CLK_HZ), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) u_f (
        .clk(clk), .rst(rst), .rxd(rxd_f), .br_cfg(br_cfg), .rx_if(if_f),
        .overrun(ovr_f), .clr_err(clr_f), .fifo_count(cnt_f));

    always @(posedge clk) begin
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL watchdog: reached %0d cycles, limit 60000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rxd(input int sel, input logic v);
        case (sel)
            0:       rxd_a = v;
            1:       rxd_p = v;
            default: rxd_f = v;
        endcase
    endtask

    function automatic logic v_of(input int sel);
        case (sel)
            0:       return if_a.rx_valid;
            1:       return if_p.rx_valid;
            default: return if_f.rx_valid;
        endcase
    endfunction

    function automatic logic [7:0] d_of(input int sel);
        case (sel)
            0:       return if_a.rx_data;
            1:       return if_p.rx_data;
            default: return if_f.rx_data;
        endcase
    endfunction

    function automatic logic [1:0] flags_of(input int sel);
        case (sel)
            0:       return {if_a.rx_ferr, if_a.rx_perr};
            1:       return {if_p.rx_ferr, if_p.rx_perr};
            default: return {if_f.rx_ferr, if_f.rx_perr};
        endcase
    endfunction

    function automatic logic r_of(input int sel);
        case (sel)
            0:       return if_a.rx_ready;
            1:       return if_p.rx_ready;
            default: return if_f.rx_ready;
        endcase
    endfunction

    function automatic logic [3:0] cnt_of(input int sel);
        case (sel)
            0:       return cnt_a;
            1:       return cnt_p;
            default: return {1'b0, cnt_f};
        endcase
    endfunction

    function automatic logic ovr_of(input int sel);
        case (sel)
            0:       return ovr_a;
            1:       return ovr_p;
            default: return ovr_f;
        endcase
    endfunction

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q_a.size();
            1:       return q_p.size();
            default: return q_f.size();
        endcase
    endfunction

    task automatic push_exp(input int sel, input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        case (sel)
            0:       q_a.push_back(e);
            1:       q_p.push_back(e);
            default: q_f.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int sel, output exp_t e);
        case (sel)
            0:       e = q_a.pop_front();
            1:       e = q_p.pop_front();
            default: e = q_f.pop_front();
        endcase
    endtask

    // Scoreboard: compare the head against the oldest expected entry on every pop.
    task automatic monitor(input int sel);
        exp_t e;
        if (v_of(sel) && r_of(sel)) begin
            check($sformatf("sb%0d_entry_expected", sel), 32'(qsize(sel) != 0), 32'd1);
            if (qsize(sel) != 0) begin
                pop_exp(sel, e);
                check($sformatf("sb%0d_data", sel), 32'(d_of(sel)), 32'(e.data));
                check($sformatf("sb%0d_perr", sel), 32'(flags_of(sel)), 32'({e.ferr, e.perr}));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            monitor(0);
            monitor(1);
            monitor(2);
        end
    end

    task automatic send_frame(input int sel, input logic [7:0] data, input logic has_par,
                              input logic par, input logic stop, input int bit_clks);
        drive_rxd(sel, 1'b0);
        wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            drive_rxd(sel, data[i]);
            wait_clks(bit_clks);
        end
        if (has_par) begin
            drive_rxd(sel, par);
            wait_clks(bit_clks);
        end
        drive_rxd(sel, stop);
        wait_clks(bit_clks);
    endtask

    task automatic wait_valid(input int sel, input int max_clks, input string name);
        int n;
        n = 0;
        while (!v_of(sel) && n < max_clks) begin
            wait_clks(1);
            n++;
        end
        check(name, 32'(v_of(sel)), 32'd1);
    endtask

    task automatic wait_drain(input int sel, input int max_clks, input string name);
        int n;
        n = 0;
        while (qsize(sel) != 0 && n < max_clks) begin
            wait_clks(1);
            n++;
        end
        check(name, 32'(qsize(sel)), 32'd0);
    endtask

    task automatic check_reset(input int sel);
        check($sformatf("rst%0d_valid", sel), 32'(v_of(sel)), 32'd0);
        check($sformatf("rst%0d_data", sel), 32'(d_of(sel)), 32'd0);
        check($sformatf("rst%0d_flags", sel), 32'(flags_of(sel)), 32'd0);
        check($sformatf("rst%0d_overrun", sel), 32'(ovr_of(sel)), 32'd0);
        check($sformatf("rst%0d_count", sel), 32'(cnt_of(sel)), 32'd0);
    endtask

    initial begin
        // {sel, br_cfg, data, has_par, par, stop, exp_perr, exp_ferr}
        vecs[0]  = '{0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{0, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0, 2'b11, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{0, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1, 2'b11, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1, 2'b11, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1, 2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1, 2'b11, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1, 2'b11, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1, 2'b10, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1, 2'b11, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        rst    = 1'b1;
        br_cfg = 2'b01;
        rxd_a  = 1'b1;
        rxd_p  = 1'b1;
        rxd_f  = 1'b1;
        clr_a  = 1'b0;
        clr_p  = 1'b0;
        clr_f  = 1'b0;
        if_a.rx_ready = 1'b0;
        if_p.rx_ready = 1'b0;
        if_f.rx_ready = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(2);

        for (int s = 0; s < 3; s++) check_reset(s);

        // Divisors at a 100 MHz system clock.
        check("div_4800", div_of(100_000_000, BAUD_4800), 32'd1302);
        check("div_9600", div_of(100_000_000, BAUD_9600), 32'd651);
        check("div_19200", div_of(100_000_000, BAUD_19200), 32'd326);
        check("div_38400", div_of(100_000_000, BAUD_38400), 32'd163);

        // 8N1 at 9600, consumer stalled: two characters queue up in order.
        wait_clks(BIT_9600);
        push_exp(0, 8'h55, 1'b0, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, BIT_9600);
        wait_valid(0, BIT_9600, "t1_valid_rise");
        check("t1_head_data", 32'(if_a.rx_data), 32'h55);
        check("t1_head_flags", 32'(flags_of(0)), 32'd0);
        wait_clks(3 * BIT_9600);
        push_exp(0, 8'hAA, 1'b0, 1'b0);
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, BIT_9600 + 1);
        wait_clks(4);
        check("t1_count_two", 32'(cnt_a), 32'd2);
        check("t1_head_still_first", 32'(if_a.rx_data), 32'h55);
        repeat (2) begin
            if_a.rx_ready = 1'b1;
            wait_clks(1);
            if_a.rx_ready = 1'b0;
            wait_clks(1);
        end
        check("t1_empty_valid", 32'(if_a.rx_valid), 32'd0);
        check("t1_empty_count", 32'(cnt_a), 32'd0);
        check("t1_sb_drained", 32'(q_a.size()), 32'd0);

        // Start-bit glitch shorter than half a bit is ignored.
        if_a.rx_ready = 1'b1;
        rxd_a = 1'b0;
        wait_clks(37);
        rxd_a = 1'b1;
        wait_clks(2 * BIT_9600);
        check("t2_no_push", 32'(cnt_a), 32'd0);
        check("t2_fsm_idle", 32'(u_a.state_q), 32'(ST_IDLE));
        push_exp(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, BIT_9600);
        wait_drain(0, BIT_9600, "t2_after_glitch_drain");

        // Framing error followed by a held-low line: exactly one entry, no retrigger.
        if_a.rx_ready = 1'b0;
        wait_clks(BIT_9600);
        push_exp(0, 8'hA5, 1'b0, 1'b1);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, BIT_9600);
        wait_clks(9 * BIT_9600);
        check("t3_one_entry", 32'(cnt_a), 32'd1);
        check("t3_head_data", 32'(if_a.rx_data), 32'hA5);
        check("t3_head_ferr", 32'(if_a.rx_ferr), 32'd1);
        rxd_a = 1'b1;
        wait_clks(2 * BIT_9600);
        check("t3_still_one", 32'(cnt_a), 32'd1);
        if_a.rx_ready = 1'b1;
        wait_drain(0, 8, "t3_drain");

        // Table-driven frames across all baud rates and parity cases.
        if_p.rx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int bclks;
            bclks  = 256 >> vecs[i].br;
            br_cfg = vecs[i].br;
            wait_clks(2 * bclks);
            push_exp(vecs[i].sel, vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].has_par, vecs[i].par,
                       vecs[i].stop, bclks);
            drive_rxd(vecs[i].sel, 1'b1);
            wait_drain(vecs[i].sel, bclks, $sformatf("vec%0d_drain", i));
        end

        // 4-deep FIFO with the consumer stalled: fifth character dropped, overrun sticky.
        br_cfg = 2'b11;
        wait_clks(2 * BIT_38400);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'(8'h11 * (i + 1));
            if (i < 4) push_exp(2, d, 1'b0, 1'b0);
            send_frame(2, d, 1'b0, 1'b0, 1'b1, BIT_38400);
        end
        wait_clks(4);
        check("t5_count_full", 32'(cnt_f), 32'd4);
        check("t5_overrun_set", 32'(ovr_f), 32'd1);
        check("t5_head_first", 32'(if_f.rx_data), 32'h11);
        clr_f = 1'b1;
        wait_clks(1);
        clr_f = 1'b0;
        check("t5_overrun_cleared", 32'(ovr_f), 32'd0);
        check("t5_count_kept", 32'(cnt_f), 32'd4);
        send_frame(2, 8'h66, 1'b0, 1'b0, 1'b1, BIT_38400);
        wait_clks(4);
        check("t5_overrun_again", 32'(ovr_f), 32'd1);

        // Reset in the middle of a frame: everything returns to reset values, nothing pushed.
        rxd_f = 1'b0;
        wait_clks(BIT_38400);
        rxd_f = 1'b1;
        wait_clks(BIT_38400);
        rxd_f = 1'b0;
        wait_clks(BIT_38400 / 2);
        rst = 1'b1;
        rxd_f = 1'b1;
        q_f.delete();
        wait_clks(2);
        rst = 1'b0;
        wait_clks(1);
        check_reset(2);
        wait_clks(3 * BIT_38400);
        check("t6_no_partial", 32'(cnt_f), 32'd0);
        if_f.rx_ready = 1'b1;
        push_exp(2, 8'h96, 1'b0, 1'b0);
        send_frame(2, 8'h96, 1'b0, 1'b0, 1'b1, BIT_38400);
        wait_drain(2, BIT_38400, "t6_after_reset_drain");

        wait_clks(4);
        check("final_a_empty", 32'(cnt_a), 32'd0);
        check("final_p_empty", 32'(cnt_p), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver. It oversamples the serial input at 16x and deframes 5–8 data bits, with optional parity and a stop-bit check. Received characters, tagged with per-character error flags, are buffered in a receive FIFO with a valid/ready output. It sits behind the top-level rxd pin and replaces the fixed 8N1 receive path; baud rate is runtime-selectable via br_cfg.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
DATA_BITS, 8, data bits per character, legal 5..8
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
FIFO_DEPTH, 8, receive FIFO entries, power of two, minimum 2

Ports:
clk  in  1  system clock, single clock domain, rising edge
rst  in  1  synchronous reset, active-high
rxd  in  1  asynchronous serial input, idles high
br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
rx_data  out  DATA_BITS  FIFO head character, LSB = first bit received
rx_perr  out  1  parity error flag for the FIFO head entry
rx_ferr  out  1  framing error flag for the FIFO head entry
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer pops the head when rx_valid && rx_ready
overrun  out  1  sticky: a character was dropped because the FIFO was full
clr_err  in  1  clears overrun
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at a clk edge) sets outputs and state as follows:
  - rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, overrun=0, fifo_count=0.
  - FSM goes to IDLE, both synchroniser flops go to 1, tick counter goes to 0.
  - Reset during a frame aborts the frame; no partial character is pushed.
- Synchroniser: rxd passes through 2 flops; rxs is the synchronised value. All sampling uses rxs.
- Tick generator:
  - Divisor DIV = round(CLK_HZ / (16 × baud)). Values at 100 MHz: 1302, 651, 326, 163.
  - Counter runs 0..DIV-1. It emits a 1-cycle tick when it wraps.
  - A br_cfg change reloads the counter to 0 on the next cycle. Changing br_cfg mid-frame is undefined, but must not hang the FSM.
- FSM states: IDLE, START, DATA, PARITY, STOP. sc is a 4-bit oversample counter, advanced on each tick.
  - IDLE: on rxs=0, clear sc and go to START.
  - START: at sc=7 (mid start bit), if rxs=0 clear sc and go to DATA. If rxs=1, treat it as a glitch and return to IDLE with nothing pushed.
  - DATA: at each sc=15, shift rxs into shift register bit position n (LSB first). After DATA_BITS samples, go to PARITY if PARITY_EN, else to STOP.
  - PARITY: at sc=15, sample rxs. perr = (XOR of data bits ^ rxs) != PARITY_ODD. Go to STOP.
  - STOP: at sc=15, sample rxs; ferr = (rxs==0). Push {ferr, perr, data} and go to IDLE.
    - On a framing error the FSM stays in IDLE until rxs=1 (break handling). No new start bit is detected while rxs stays low.
- Push-to-rx_valid latency is 1 clk: the push registers, and rx_valid rises on the next edge.
- FIFO behaviour:
  - First-word-fall-through; rx_data, rx_perr and rx_ferr reflect the head entry whenever rx_valid=1.
  - Pop when rx_valid && rx_ready.
  - Push while full and no pop in the same cycle: the character is dropped, overrun is set, and existing contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, count is unchanged, no overrun.
  - Push and pop in the same cycle while empty: not possible, because FWFT needs 1 cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun stays set until clr_err. If clr_err and a new overrun occur in the same cycle, overrun stays 1.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum;
  - baud rate constants (4800/9600/19200/38400);
  - a function div_of(clk_hz, baud) returning the rounded divisor;
  - the OVERSAMPLE=16 constant.
- Sub-module uart_baud_tick implements the divisor mux and tick counter (clk, rst, br_cfg -> tick). The FIFO is inline.

Test Plan:
- 9600 8N1: drive start 0, data 1,0,1,0,1,0,1,0, stop 1, at 104167 ns per bit (a 104310 ns bit time also passes) -> rx_valid rises within 1 bit time after stop, rx_data=0x55, perr=0, ferr=0.
- Second frame with data bits 0,1,0,1,0,1,0,1 after 6.5 ms idle, rx_ready held 0 -> FIFO holds 0x55 then 0xAA, fifo_count=2; pulse rx_ready twice -> popped in order, rx_valid=0.
- Start glitch: rxd low for 30 µs at 9600 -> no push, FSM back in IDLE; a valid 0x3C frame afterwards is received correctly.
- Framing error: 0xA5 with stop bit 0, then line held low 1 ms -> one entry with ferr=1 and no further pushes until rxd returns high.
- PARITY_EN=1, PARITY_ODD=0 at 38400: 0x07 with parity bit 1 -> perr=0; 0x07 with parity bit 0 -> perr=1.
- FIFO_DEPTH=4 with rx_ready=0: send 5 characters -> fifo_count=4, overrun=1, head still the first character; clr_err -> overrun=0; rst mid-frame -> all outputs return to reset values.
